// File: rtl/mct_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mct_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_MM = 1'b1
    } mct_gnt_e;

    localparam logic [1:0] CU_B = 2'd0;
    localparam logic [1:0] CU_H = 2'd1;
    localparam logic [1:0] CU_W = 2'd3;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mct_if.sv
// Bundle of the IF/MM request ports and the byte-wide RAM port around mem_ctrl.
// Handshake: a requester raises e with stable address/data and holds it until its
// ok pulse; ok is high for exactly one cycle and the requester drops e in that cycle.
interface mct_if;
    logic        if_mct_e;
    logic [31:0] if_mct_a;
    logic [31:0] if_mct_n_o;
    logic        if_mct_ok;

    logic        mm_mct_e;
    logic [31:0] mm_mct_a;
    logic        mm_mct_wr;
    logic [1:0]  mm_mct_cu;
    logic [31:0] mm_mct_n_i;
    logic [31:0] mm_mct_n_o;
    logic        mm_mct_ok;

    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    modport slave (
        input  if_mct_e, if_mct_a,
        output if_mct_n_o, if_mct_ok,
        input  mm_mct_e, mm_mct_a, mm_mct_wr, mm_mct_cu, mm_mct_n_i,
        output mm_mct_n_o, mm_mct_ok,
        output ram_a, ram_wr, ram_dout,
        input  ram_din
    );

    modport master (
        output if_mct_e, if_mct_a,
        input  if_mct_n_o, if_mct_ok,
        output mm_mct_e, mm_mct_a, mm_mct_wr, mm_mct_cu, mm_mct_n_i,
        input  mm_mct_n_o, mm_mct_ok,
        input  ram_a, ram_wr, ram_dout,
        output ram_din
    );
endinterface

// File: rtl/mct_arb.sv
// Fixed-priority grant between MM and IF; only meaningful while the controller is idle.
import mct_pkg::*;

module mct_arb (
    input  logic     en,
    input  logic     mm_e,
    input  logic     if_e,
    output logic     grant,
    output mct_gnt_e gnt
);
    assign grant = en & (mm_e | if_e);
    assign gnt   = mm_e ? GNT_MM : GNT_IF;
endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and the memory stage,
// running one 1-4 byte transaction at a time and assembling little-endian read words.
import mct_pkg::*;

module mem_ctrl (
    input  logic       clk,
    input  logic       rst,
    mct_if.slave       bus,
    output mct_state_e dbg_state
);
    mct_state_e  state;
    mct_gnt_e    gnt;
    logic [1:0]  cnt;
    logic [1:0]  last;
    logic [31:0] base;
    logic        wr;
    logic [31:0] data;
    logic [31:0] rd_buf;
    logic [31:0] ram_a_r;
    logic        ram_wr_r;
    logic [7:0]  ram_dout_r;
    logic        ok_if_r;
    logic        ok_mm_r;

    logic        grant;
    mct_gnt_e    gnt_w;
    logic [31:0] sel_a;
    logic        sel_wr;
    logic [1:0]  sel_cu;
    logic [31:0] sel_d;
    logic [1:0]  cnt_nx;
    logic [1:0]  cnt_prev;

    mct_arb u_arb (
        .en   (state == ST_IDLE),
        .mm_e (bus.mm_mct_e),
        .if_e (bus.if_mct_e),
        .grant(grant),
        .gnt  (gnt_w)
    );

    // IF is always a 4-byte fetch with no store data.
    always_comb begin
        sel_a  = bus.if_mct_a;
        sel_wr = 1'b0;
        sel_cu = CU_W;
        sel_d  = 32'd0;
        if (gnt_w == GNT_MM) begin
            sel_a  = bus.mm_mct_a;
            sel_wr = bus.mm_mct_wr;
            sel_cu = bus.mm_mct_cu;
            sel_d  = bus.mm_mct_n_i;
        end
    end

    assign cnt_nx   = cnt + 2'd1;
    assign cnt_prev = cnt - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= GNT_IF;
            cnt        <= 2'd0;
            last       <= 2'd0;
            base       <= 32'd0;
            wr         <= 1'b0;
            data       <= 32'd0;
            rd_buf     <= 32'd0;
            ram_a_r    <= 32'd0;
            ram_wr_r   <= 1'b0;
            ram_dout_r <= 8'd0;
            ok_if_r    <= 1'b0;
            ok_mm_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt        <= gnt_w;
                        base       <= sel_a;
                        wr         <= sel_wr;
                        last       <= sel_cu;
                        data       <= sel_d;
                        cnt        <= 2'd0;
                        ram_a_r    <= sel_a;
                        ram_wr_r   <= sel_wr;
                        ram_dout_r <= sel_wr ? sel_d[7:0] : 8'd0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Byte cnt-1 was addressed last cycle and is on ram_din now.
                    if (!wr && cnt != 2'd0)
                        rd_buf[{cnt_prev, 3'b000} +: 8] <= bus.ram_din;
                    if (cnt == last) begin
                        ram_a_r    <= 32'd0;
                        ram_wr_r   <= 1'b0;
                        ram_dout_r <= 8'd0;
                        ok_mm_r    <= (gnt == GNT_MM);
                        ok_if_r    <= (gnt == GNT_IF);
                        state      <= ST_DONE;
                    end else begin
                        cnt        <= cnt_nx;
                        ram_a_r    <= base + {30'd0, cnt_nx};
                        ram_dout_r <= wr ? byte_sel(data, cnt_nx) : 8'd0;
                    end
                end
                ST_DONE: begin
                    ok_mm_r <= 1'b0;
                    ok_if_r <= 1'b0;
                    cnt     <= 2'd0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_a      = ram_a_r;
    assign bus.ram_wr     = ram_wr_r;
    assign bus.ram_dout   = ram_dout_r;
    assign bus.mm_mct_ok  = ok_mm_r;
    assign bus.if_mct_ok  = ok_if_r;
    assign bus.mm_mct_n_o = rd_buf;
    // The final fetched byte is never buffered; it is forwarded straight from the RAM.
    assign bus.if_mct_n_o = ok_if_r ? {bus.ram_din, rd_buf[23:0]} : 32'd0;
    assign dbg_state      = state;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: behavioural byte RAM, hand-computed expected values.
import mct_pkg::*;

module tb_mem_ctrl;
    logic       clk;
    logic       rst;
    mct_state_e dbg_state;

    mct_if bus ();

    mem_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [7:0] ram_mem [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        bus.ram_din <= ram_rd(bus.ram_a);
        if (bus.ram_wr) ram_mem[bus.ram_a] = bus.ram_dout;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_a_q[$];
    logic [31:0] obs_n;
    logic [7:0]  obs_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_len"}, obs_a_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_a_q.size() > 0)
            check(tag, obs_a_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_a_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the ok cycle.
    task automatic mm_txn(input logic [31:0] a, input logic w, input logic [1:0] cu,
                          input logic [31:0] d, input int drop_at,
                          output int lat, output int wr_cnt);
        int  cyc;
        bit  seen;
        obs_a_q.delete();
        bus.mm_mct_a   = a;
        bus.mm_mct_wr  = w;
        bus.mm_mct_cu  = cu;
        bus.mm_mct_n_i = d;
        bus.mm_mct_e   = 1'b1;
        cyc = 0; seen = 0; wr_cnt = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == drop_at) bus.mm_mct_e = 1'b0;
            if (bus.mm_mct_ok) begin
                seen    = 1;
                obs_n   = bus.mm_mct_n_o;
                obs_din = bus.ram_din;
                check("wr_in_done", bus.ram_wr, 1'b0);
            end else begin
                obs_a_q.push_back(bus.ram_a);
                if (bus.ram_wr) wr_cnt++;
            end
        end
        check("mm_ok_seen", seen, 1'b1);
        bus.mm_mct_e = 1'b0;
        lat = cyc;
        @(negedge clk);
        check("mm_ok_pulse", bus.mm_mct_ok, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  lat, wrc, cyc;
        bit  if_early, seen;

        rst = 1'b1;
        bus.if_mct_e = 0; bus.if_mct_a = 0;
        bus.mm_mct_e = 0; bus.mm_mct_a = 0; bus.mm_mct_wr = 0;
        bus.mm_mct_cu = 0; bus.mm_mct_n_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_a", bus.ram_a, 32'd0);
        check("rst_ram_wr", bus.ram_wr, 1'b0);
        check("rst_ram_dout", bus.ram_dout, 8'd0);
        check("rst_mm_ok", bus.mm_mct_ok, 1'b0);
        check("rst_if_ok", bus.if_mct_ok, 1'b0);
        check("rst_mm_n_o", bus.mm_mct_n_o, 32'd0);
        check("rst_if_n_o", bus.if_mct_n_o, 32'd0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Word load
        ram_mem[32'h100] = 8'h11; ram_mem[32'h101] = 8'h22;
        ram_mem[32'h102] = 8'h33; ram_mem[32'h103] = 8'h44;
        mm_txn(32'h100, 1'b0, CU_W, 32'd0, 0, lat, wrc);
        check("wl_lat", lat, 5);
        check("wl_buf", obs_n[23:0], 24'h332211);
        check("wl_din", obs_din, 8'h44);
        check("wl_wr", wrc, 0);
        exp_q.push_back(32'h100); exp_q.push_back(32'h101);
        exp_q.push_back(32'h102); exp_q.push_back(32'h103);
        check_addrs("wl_addr");

        // Halfword store
        ram_mem[32'h202] = 8'h77;
        mm_txn(32'h200, 1'b1, CU_H, 32'hDEADBEEF, 0, lat, wrc);
        check("hs_lat", lat, 3);
        check("hs_wr_cycles", wrc, 2);
        check("hs_b0", ram_rd(32'h200), 8'hEF);
        check("hs_b1", ram_rd(32'h201), 8'hBE);
        check("hs_b2", ram_rd(32'h202), 8'h77);
        check("hs_buf_kept", bus.mm_mct_n_o, 32'h00332211);
        exp_q.push_back(32'h200); exp_q.push_back(32'h201);
        check_addrs("hs_addr");

        // Contention: MM byte read and IF fetch raised together
        ram_mem[32'h300] = 8'hA1; ram_mem[32'h301] = 8'hB2;
        ram_mem[32'h302] = 8'hC3; ram_mem[32'h303] = 8'hD4;
        bus.mm_mct_a = 32'h400; bus.mm_mct_wr = 0; bus.mm_mct_cu = CU_B;
        bus.mm_mct_e = 1; bus.if_mct_a = 32'h300; bus.if_mct_e = 1;
        cyc = 0; seen = 0; if_early = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk); cyc++;
            if (bus.if_mct_ok) if_early = 1;
            if (bus.mm_mct_ok) begin seen = 1; obs_din = bus.ram_din; end
        end
        bus.mm_mct_e = 0;
        check("ct_mm_lat", cyc, 2);
        check("ct_mm_byte", obs_din, 8'h5A);
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk); cyc++;
            if (bus.mm_mct_ok) if_early = 1;
            if (bus.if_mct_ok) begin seen = 1; obs_n = bus.if_mct_n_o; end
        end
        bus.if_mct_e = 0;
        check("ct_if_gap", cyc, 6);
        check("ct_if_word", obs_n, 32'hD4C3B2A1);
        check("ct_no_cross_ok", if_early, 1'b0);
        @(negedge clk);
        check("ct_if_ok_pulse", bus.if_mct_ok, 1'b0);
        check("ct_if_n_o_idle", bus.if_mct_n_o, 32'd0);

        // Address wrap
        mm_txn(32'hFFFFFFFE, 1'b0, CU_W, 32'd0, 0, lat, wrc);
        check("wr_buf", obs_n[23:0], 24'h5AA5A4);
        check("wr_din", obs_din, 8'h5B);
        exp_q.push_back(32'hFFFFFFFE); exp_q.push_back(32'hFFFFFFFF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        check_addrs("wrap_addr");

        // Reset in the middle of a word store
        for (int i = 0; i < 4; i++) ram_mem[32'h500 + i] = 8'h00;
        bus.mm_mct_a = 32'h500; bus.mm_mct_wr = 1; bus.mm_mct_cu = CU_W;
        bus.mm_mct_n_i = 32'h87654321; bus.mm_mct_e = 1;
        repeat (3) @(negedge clk);
        check("rs_wr_before", bus.ram_wr, 1'b1);
        check("rs_a_before", bus.ram_a, 32'h502);
        rst = 1'b1;
        #1;
        check("rs_wr_async", bus.ram_wr, 1'b0);
        check("rs_a_async", bus.ram_a, 32'd0);
        check("rs_state", dbg_state, ST_IDLE);
        bus.mm_mct_e = 0;
        @(negedge clk);
        check("rs_no_ok", bus.mm_mct_ok, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rs_no_ok2", bus.mm_mct_ok, 1'b0);
        check("rs_m0", ram_rd(32'h500), 8'h21);
        check("rs_m1", ram_rd(32'h501), 8'h43);
        check("rs_m2", ram_rd(32'h502), 8'h00);
        check("rs_m3", ram_rd(32'h503), 8'h00);
        mm_txn(32'h501, 1'b0, CU_B, 32'd0, 0, lat, wrc);
        check("rs_next_lat", lat, 2);
        check("rs_next_byte", obs_din, 8'h43);

        // Requester drops e during a byte store
        mm_txn(32'h600, 1'b1, CU_B, 32'h000000AB, 1, lat, wrc);
        check("dr_lat", lat, 2);
        check("dr_wr_cycles", wrc, 1);
        check("dr_byte", ram_rd(32'h600), 8'hAB);
        check("dr_state", dbg_state, ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
